mips_multicycle_control: RTL

//  Multicycle MIPS control unit: FSM sequencing FETCH/DECODE/EXEC/MEM/WB, replacing the single-cycle decoder.

---
 rtl/mips_multicycle_control.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//   Multicycle MIPS control unit. An FSM steps each instruction through
//   FETCH -> DECODE -> EXEC -> MEM -> WB as needed. It drives the PC, IR,
//   register-file, ALU and memory controls. Memory uses a req/ack handshake
//   with an optional wait timeout. Unknown opcodes and memory timeouts both
//   park the FSM in TRAP until nrst is asserted.
// Ports
//   clk, nrst          clock (rising edge), asynchronous active-low reset
//   opcode             IR[31:26], valid from the cycle after ir_write
//   alu_zero           ALU zero flag, used by BEQ/BNE in EXEC
//   mem_ack            memory completes the current access this cycle
//   mem_req/we/size    memory request, store select, access size
//   pc_write/pc_src    PC load enable and source select
//   ir_write           IR load enable
//   reg_write/reg_dst  register-file write enable and destination select
//   wb_src             write-back data source
//   alu_src_a/b        ALU operand selects
//   sign_ext           immediate extension mode
//   alu_op             ALU operation code
//   instr_done         pulse on the last cycle of every instruction
//   illegal_op         sticky flag: an unknown opcode was decoded
//   mem_timeout        sticky flag: a memory access never received mem_ack
module mips_multicycle_control #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [5:0]         opcode,
  input  logic               alu_zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic [1:0]         mem_size,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               sign_ext,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               mem_timeout
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_BNE   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(6);

  // Keep the counter at least one bit wide when the timeout is disabled.
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             run_q;       // low while in reset and for the first edge after release
  logic             illegal_q, timeout_q;
  logic             set_illegal, set_timeout;
  logic             tmo_hit;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_LBU, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    is_load = (op == OP_LBU) || (op == OP_LHU) || (op == OP_LW);
  endfunction

  // Timeout fires on the last permitted wait cycle; an ack in that same
  // cycle is handled first by the callers, so the ack wins.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      wait_cnt  <= '0;
      run_q     <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (run_q && state_q == S_DECODE) begin
        op_q <= opcode;
      end
      // Count only while an access is stalled in the same state.
      if (mem_req && !mem_ack && state_d == state_q) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_size    = 2'b10;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 2'b01;
    wb_src      = 2'b01;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    sign_ext    = 1'b1;
    alu_op      = ALU_RTYPE;
    instr_done  = 1'b0;

    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = ALU_ADD;
          if (mem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (tmo_hit) begin
            set_timeout = 1'b1;
            state_d     = S_TRAP;
          end
        end

        S_DECODE: begin
          // Branch target is computed here into ALUOut for use in EXEC.
          alu_src_b = 2'b11;
          alu_op    = ALU_ADD;
          if (!is_legal(opcode)) begin
            set_illegal = 1'b1;
            state_d     = S_TRAP;
          end else if (opcode == OP_J) begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end

        S_EXEC: begin
          alu_src_a = 1'b1;
          state_d   = S_WB;
          case (op_q)
            OP_R: begin
              alu_src_b = 2'b00;
              alu_op    = ALU_RTYPE;
            end
            OP_ADDI, OP_ADDIU: begin
              alu_src_b = 2'b10;
              alu_op    = ALU_ADD;
            end
            OP_ANDI: begin
              alu_src_b = 2'b10;
              alu_op    = ALU_AND;
              sign_ext  = 1'b0;
            end
            OP_ORI: begin
              alu_src_b = 2'b10;
              alu_op    = ALU_OR;
              sign_ext  = 1'b0;
            end
            OP_SLTI, OP_SLTIU: begin
              alu_src_b = 2'b10;
              alu_op    = ALU_SLT;
            end
            OP_LBU, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: begin
              alu_src_b = 2'b10;
              alu_op    = ALU_ADD;
              state_d   = S_MEM;
            end
            OP_BEQ, OP_BNE: begin
              alu_src_b  = 2'b00;
              alu_op     = (op_q == OP_BEQ) ? ALU_SUB : ALU_BNE;
              pc_write   = (op_q == OP_BEQ) ? alu_zero : ~alu_zero;
              pc_src     = 2'b01;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
            OP_JAL: begin
              // Link value is the PC already advanced to PC+4 in FETCH.
              reg_write  = 1'b1;
              reg_dst    = 2'b10;
              wb_src     = 2'b10;
              pc_write   = 1'b1;
              pc_src     = 2'b10;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
          endcase
        end

        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = is_store(op_q);
          case (op_q)
            OP_LHU, OP_SH: mem_size = 2'b01;
            OP_LBU, OP_SB: mem_size = 2'b00;
            default:       mem_size = 2'b10;
          endcase
          if (mem_ack) begin
            if (is_store(op_q)) begin
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (tmo_hit) begin
            set_timeout = 1'b1;
            state_d     = S_TRAP;
          end
        end

        S_WB: begin
          reg_write  = 1'b1;
          wb_src     = is_load(op_q) ? 2'b00 : 2'b01;
          reg_dst    = (op_q == OP_R) ? 2'b01 : 2'b00;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end

        S_TRAP: state_d = S_TRAP;

        default: state_d = S_FETCH;
      endcase
    end
  end

  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;

endmodule
